pipe_stage_fifo: RTL and testbench
==================================

Name: pipe_stage_fifo

Overview:
Parametrised elastic pipeline buffer, the next generation of the fixed enable-only inter-stage registers (fetch/decode, decode/execute, execute/memory, memory/writeback).
- Adds valid/ready handshake, configurable depth and width, synchronous flush, and bubble (NOP) injection.
- Lets hazard logic stall or squash any stage without per-buffer custom RTL.
- One instance sits between each pair of pipeline stages in the processor top level.

Parameters:
DATA_W, 32, payload width in bits (any value >= 1)
DEPTH, 2, number of entries; power of two, >= 2
BUBBLE_VAL, 0, value driven on o_data while o_valid=0 (NOP encoding)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
i_valid  input  1  upstream stage offers i_data
o_ready  output  1  buffer can accept this cycle
i_data  input  DATA_W  upstream payload
o_valid  output  1  head entry valid for downstream
i_ready  input  1  downstream accepts head this cycle
o_data  output  DATA_W  head payload, or BUBBLE_VAL when empty
i_flush  input  1  synchronous squash of all entries (branch/interrupt)
o_count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst=0, asynchronous):
  - count=0, wr_ptr=0, rd_ptr=0.
  - o_valid=0, o_ready=1, o_data=BUBBLE_VAL, o_count=0.
  - Storage contents are not reset.
- Handshake:
  - push = i_valid & o_ready.
  - pop = o_valid & i_ready.
  - i_data is sampled on the push edge.
  - Upstream may hold i_valid high with changing data; only the push edge matters.
- Ready and valid are combinational from count only:
  - o_ready = (count < DEPTH); no pass-through when full, even if a pop occurs the same cycle.
  - o_valid = (count != 0).
- Latency: a push to an empty buffer gives o_valid=1 and o_data=that value on the next cycle (1-cycle latency). No combinational i_data->o_data path.
- Occupancy states, derived from count:
  - EMPTY (count==0): push only -> PARTIAL.
  - PARTIAL: push only -> count+1 (FULL if count reaches DEPTH); pop only -> count-1 (EMPTY if 0); push & pop -> count unchanged, head advances, tail written.
  - FULL (count==DEPTH): o_ready=0; pop -> PARTIAL.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is one bit wider, so full and empty are unambiguous.
- Flush:
  - At the next edge: count=0, rd_ptr=wr_ptr=0, and o_valid=0 in the following cycle.
  - Flush overrides a push and a pop in the same cycle; the pushed data is discarded and not counted as accepted.
- Reset mid-operation: async reset clears state immediately regardless of the handshake; the first edge after rst is released behaves as from EMPTY.
- o_data when count==0 is exactly BUBBLE_VAL, so downstream control decoding sees a NOP.
- o_count equals count at all times.

Optional Feature:
Macro PIPE_STAGE_FIFO_PERF_EN.
- Defined: adds outputs o_stall_cnt[15:0] and o_bubble_cnt[15:0].
  - o_stall_cnt increments on each cycle with i_valid & ~o_ready.
  - o_bubble_cnt increments on each cycle with ~o_valid & i_ready.
  - Both counters saturate at 16'hFFFF, clear on reset, and are unaffected by flush.
- Not defined: the ports and counters do not exist; core behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - the default NOP encoding constant used for BUBBLE_VAL;
  - a pointer-width constant function (clog2 with a minimum of 1);
  - performance counter width and saturation constants.
- One natural sub-module, pipe_fifo_mem: a DEPTH x DATA_W register array with a write port (we, waddr, wdata) and a combinational read (raddr -> rdata).
- pipe_stage_fifo owns the pointers, count, flush and the bubble mux.

Test Plan:
- Reset then idle, DATA_W=32, BUBBLE_VAL=32'h0 -> o_valid=0, o_ready=1, o_data=0, o_count=0; stays so with i_valid=0.
- Push 32'hA5A5_0001 with i_ready=0 -> next cycle o_valid=1, o_data=32'hA5A5_0001, o_count=1.
- Second push 32'h0000_0002 (i_ready still 0) -> o_count=2, o_ready=0; a third offer is not accepted.
- Still FULL (DEPTH=2), pop with i_valid=1 and data 32'h3 -> that cycle o_ready=0, so 32'h3 is not pushed. Next cycle o_count=1 and head is 32'h0000_0002.
- Continuous push & pop for 20 cycles with an incrementing pattern 0..19 -> o_count constant at 1, outputs in order 0..19, pointers wrap with no loss.
- Flush asserted together with a push of 32'hDEAD at count=1 -> next cycle o_count=0, o_valid=0, o_data=BUBBLE_VAL; 32'hDEAD never appears on o_data.
- Async rst pulsed low mid-cycle at count=2 -> outputs clear immediately, before the next edge. With PIPE_STAGE_FIFO_PERF_EN defined, 5 blocked cycles give o_stall_cnt=5.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline stage buffers.
package pipe_pkg;

  localparam logic [31:0] NOP_ENC = 32'h0000_0000;

  localparam int unsigned PERF_W   = 16;
  localparam logic [PERF_W-1:0] PERF_SAT = '1;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  // Pointer width for a given depth, never narrower than one bit
  function automatic int unsigned ptrWidth(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pipe_fifo_mem.sv
// Storage array for pipe_stage_fifo: one write port, combinational read, no reset.
module pipe_fifo_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_stage_fifo.sv
// Elastic valid/ready pipeline buffer with flush and NOP bubble output.
// Optional stall/bubble counters are enabled by defining PIPE_STAGE_FIFO_PERF_EN.
module pipe_stage_fifo
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(NOP_ENC),
  localparam int unsigned PTR_W = ptrWidth(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_flush,
  output logic [CNT_W-1:0]  o_count
`ifdef PIPE_STAGE_FIFO_PERF_EN
  ,
  output logic [PERF_W-1:0] o_stall_cnt,
  output logic [PERF_W-1:0] o_bubble_cnt
`endif
);

  logic [PTR_W-1:0]  wrPtr, wrPtrNext;
  logic [PTR_W-1:0]  rdPtr, rdPtrNext;
  logic [CNT_W-1:0]  count, countNext;
  logic [DATA_W-1:0] rdData;
  logic              push, pop, memWe;
  occ_e              occ;

  // Occupancy class is a pure function of count
  always_comb begin
    occ = OCC_PARTIAL;
    if (count == '0)                      occ = OCC_EMPTY;
    else if (count == CNT_W'(DEPTH))      occ = OCC_FULL;
  end

  assign o_ready = (occ != OCC_FULL);
  assign o_valid = (occ != OCC_EMPTY);
  assign push    = i_valid & o_ready;
  assign pop     = o_valid & i_ready;
  assign o_count = count;
  assign o_data  = (occ == OCC_EMPTY) ? BUBBLE_VAL : rdData;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtrNext;
      rdPtr <= rdPtrNext;
      count <= countNext;
    end
  end

  // Flush wins over any same-cycle push or pop
  always_comb begin
    wrPtrNext = wrPtr;
    rdPtrNext = rdPtr;
    countNext = count;
    memWe     = 1'b0;
    if (i_flush) begin
      wrPtrNext = '0;
      rdPtrNext = '0;
      countNext = '0;
    end else begin
      memWe = push;
      if (push) wrPtrNext = wrPtr + PTR_W'(1);
      if (pop)  rdPtrNext = rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   countNext = count + CNT_W'(1);
        2'b01:   countNext = count - CNT_W'(1);
        default: countNext = count;
      endcase
    end
  end

  pipe_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (memWe),
    .waddr (wrPtr),
    .wdata (i_data),
    .raddr (rdPtr),
    .rdata (rdData)
  );

`ifdef PIPE_STAGE_FIFO_PERF_EN
  // Saturating stall/bubble counters; flush leaves them alone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_stall_cnt  <= '0;
      o_bubble_cnt <= '0;
    end else begin
      if (i_valid && !o_ready && o_stall_cnt != PERF_SAT)
        o_stall_cnt <= o_stall_cnt + PERF_W'(1);
      if (!o_valid && i_ready && o_bubble_cnt != PERF_SAT)
        o_bubble_cnt <= o_bubble_cnt + PERF_W'(1);
    end
  end
`else
  // No performance counters in this build
`endif

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Randomised self-checking bench for pipe_stage_fifo against a queue-based model.
module tb_pipe_stage_fifo;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] BUBBLE = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_ready, i_flush;
  logic [31:0] i_data;
  logic        o_ready, o_valid;
  logic [31:0] o_data;
  logic [1:0]  o_count;
`ifdef PIPE_STAGE_FIFO_PERF_EN
  logic [15:0] o_stall_cnt, o_bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] mq[$];

  always #5 clk = ~clk;

  pipe_stage_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .BUBBLE_VAL (BUBBLE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .i_flush (i_flush),
    .o_count (o_count)
`ifdef PIPE_STAGE_FIFO_PERF_EN
    ,
    .o_stall_cnt  (o_stall_cnt),
    .o_bubble_cnt (o_bubble_cnt)
`endif
  );

  function automatic logic [31:0] expData();
    return (mq.size() != 0) ? mq[0] : BUBBLE;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, sample #1 later
  task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic f);
    bit acc, take;
    i_valid = v; i_data = d; i_ready = r; i_flush = f;
    acc  = v && (mq.size() < DEPTH);
    take = r && (mq.size() != 0);
    @(posedge clk);
    if (f) mq.delete();
    else begin
      if (take) void'(mq.pop_front());
      if (acc)  mq.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_valid = 0; i_ready = 0; i_flush = 0; i_data = '0;
    mq.delete();
    #12;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", o_ready); end
    checks++; if (o_data !== BUBBLE) begin errors++; $display("FAIL reset_data got=%h want=%h", o_data, BUBBLE); end
    checks++; if (o_count !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", o_count); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 32'h0, 0, 0);
      checks++;
      if (o_valid !== 1'b0 || o_count !== 2'd0 || o_data !== BUBBLE) begin
        errors++; $display("FAIL idle valid=%b count=%0d data=%h want 0/0/%h", o_valid, o_count, o_data, BUBBLE);
      end
    end
  endtask

  task automatic test_fill();
    cycle(1, 32'hA5A5_0001, 0, 0);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL push1_valid got=%b want=1", o_valid); end
    checks++; if (o_data !== 32'hA5A5_0001) begin errors++; $display("FAIL push1_data got=%h want=a5a50001", o_data); end
    checks++; if (o_count !== 2'd1) begin errors++; $display("FAIL push1_count got=%0d want=1", o_count); end
    cycle(1, 32'h0000_0002, 0, 0);
    checks++; if (o_count !== 2'd2) begin errors++; $display("FAIL push2_count got=%0d want=2", o_count); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b want=0", o_ready); end
    cycle(1, 32'h0000_0033, 0, 0);
    checks++; if (o_count !== 2'd2 || o_data !== 32'hA5A5_0001) begin
      errors++; $display("FAIL third_offer count=%0d data=%h want 2/a5a50001", o_count, o_data);
    end
  endtask

  task automatic test_full_pop();
    i_valid = 1; i_data = 32'h3; i_ready = 1;
    #1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready got=%b want=0", o_ready); end
    cycle(1, 32'h3, 1, 0);
    checks++; if (o_count !== 2'd1) begin errors++; $display("FAIL full_pop_count got=%0d want=1", o_count); end
    checks++; if (o_data !== 32'h0000_0002) begin errors++; $display("FAIL full_pop_head got=%h want=00000002", o_data); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seen[$];
    for (int i = 0; i < 20; i++) begin
      seen.push_back(o_data);
      cycle(1, 32'(i), 1, 0);
      checks++; if (o_count !== 2'd1) begin errors++; $display("FAIL b2b_count[%0d] got=%0d want=1", i, o_count); end
    end
    // Head sequence must be the held 2 followed by 0..18
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (seen[i] !== ((i == 0) ? 32'h2 : 32'(i - 1))) begin
        errors++; $display("FAIL b2b_order[%0d] got=%h want=%h", i, seen[i], (i == 0) ? 32'h2 : 32'(i - 1));
      end
    end
    checks++; if (o_data !== 32'd19) begin errors++; $display("FAIL b2b_tail got=%h want=13", o_data); end
  endtask

  task automatic test_flush();
    cycle(1, 32'hDEAD, 0, 1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_count !== 2'd0 || o_valid !== 1'b0 || o_data !== BUBBLE) begin
        errors++; $display("FAIL flush[%0d] count=%0d valid=%b data=%h want 0/0/%h", i, o_count, o_valid, o_data, BUBBLE);
      end
      cycle(0, 32'h0, 1, 0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic v, r, f;
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 15) == 0);
      cycle(v, $urandom, r, f);
      checks++;
      if (o_count !== 2'(mq.size()) || o_valid !== (mq.size() != 0) ||
          o_ready !== (mq.size() < DEPTH) || o_data !== expData()) begin
        errors++;
        $display("FAIL random[%0d] count=%0d valid=%b ready=%b data=%h want %0d/%b/%b/%h", i,
                 o_count, o_valid, o_ready, o_data, mq.size(), mq.size() != 0, mq.size() < DEPTH, expData());
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(0, 32'h0, 0, 1);
    cycle(1, 32'h1111, 0, 0);
    cycle(1, 32'h2222, 0, 0);
    checks++; if (o_count !== 2'd2) begin errors++; $display("FAIL pre_arst_count got=%0d want=2", o_count); end
    #2 rst = 1'b0;
    mq.delete();
    #1;
    checks++;
    if (o_count !== 2'd0 || o_valid !== 1'b0 || o_ready !== 1'b1 || o_data !== BUBBLE) begin
      errors++; $display("FAIL arst count=%0d valid=%b ready=%b data=%h want 0/0/1/%h", o_count, o_valid, o_ready, o_data, BUBBLE);
    end
    #2 rst = 1'b1;
    cycle(1, 32'h55, 0, 0);
    checks++; if (o_count !== 2'd1 || o_data !== 32'h55) begin
      errors++; $display("FAIL post_arst count=%0d data=%h want 1/55", o_count, o_data);
    end
`ifdef PIPE_STAGE_FIFO_PERF_EN
    cycle(1, 32'h66, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 32'(i), 0, 0);
    checks++; if (o_stall_cnt !== 16'd5) begin errors++; $display("FAIL stall_cnt got=%0d want=5", o_stall_cnt); end
    checks++; if (o_bubble_cnt !== 16'd0) begin errors++; $display("FAIL bubble_cnt got=%0d want=0", o_bubble_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_pop();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
